// File: rtl/io_port_ctrl.sv
// io_port_ctrl -- CPU-side IO port: TX FIFO toward a UART transmitter, RX pop,
// a free-running cycle counter with a byte-readable snapshot, and a stop/drain/halt FSM.
//
// Optional feature: define IO_PORT_CTRL_RX_EN to enable the UART receive path.
// Without it, rx_rd_out is tied low and reads of 0x30000 return 0x00.
//
// Ports
//   clk_in, rst_in (async, active low), rdy_in (global freeze when low)
//   addr_in/wdata_in/wr_in      CPU bus request (IO region: addr_in[17:16]==2'b11)
//   rdata_out/io_sel_out        registered read byte and IO-access flag
//   io_buffer_full_out          TX FIFO almost full
//   tx_data_out/tx_wr_out       byte and strobe toward the transmitter
//   tx_full_in                  transmitter cannot accept
//   rx_data_in/rx_empty_in      receive byte and empty flag
//   rx_rd_out                   receive pop strobe
//   halt_out                    stopped and fully drained
//   ovf_out                     sticky: push arrived while FIFO full
//
// CNT_INIT sets the value the cycle counter is reset to (0 in normal use);
// it allows the snapshot path to be exercised at arbitrary counter values.

module io_port_ctrl #(
   parameter int          TX_DEPTH  = 8,
   parameter int          AF_MARGIN = 2,
   parameter logic [31:0] CNT_INIT  = 32'h0000_0000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] addr_in,
   input  logic [7:0]  wdata_in,
   input  logic        wr_in,
   output logic [7:0]  rdata_out,
   output logic        io_sel_out,
   output logic        io_buffer_full_out,
   output logic [7:0]  tx_data_out,
   output logic        tx_wr_out,
   input  logic        tx_full_in,
   input  logic [7:0]  rx_data_in,
   input  logic        rx_empty_in,
   output logic        rx_rd_out,
   output logic        halt_out,
   output logic        ovf_out
);

   localparam int PW = $clog2(TX_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

   state_t         state_q, state_d;
   logic [PW-1:0]  head_q, head_d;
   logic [PW-1:0]  tail_q, tail_d;
   logic [CW-1:0]  count_q, count_d;
   logic [31:0]    cnt_q, cnt_d;
   logic [31:0]    snap_q, snap_d;
   logic [7:0]     rdata_q, rdata_d;
   logic           io_sel_q, io_sel_d;
   logic           ovf_q, ovf_d;

   logic [7:0]     fifo_mem [TX_DEPTH];

   logic           io_hit, io_rd, io_wr;
   logic [2:0]     sub;
   logic           fifo_empty, fifo_full;
   logic           push_req, push, pop;
   logic [7:0]     push_data;
   logic           rx_pop;
   logic [7:0]     rx_byte;

   // Only addr_in[17:16] and addr_in[2:0] take part in the decode.
   wire unused_addr = &{1'b0, addr_in[31:18], addr_in[15:3]};

   assign io_hit = (addr_in[17:16] == 2'b11);
   assign sub    = addr_in[2:0];
   assign io_rd  = rdy_in & io_hit & ~wr_in;
   // Writes are accepted only while running; DRAIN/HALTED ignore the CPU.
   assign io_wr  = rdy_in & io_hit & wr_in & (state_q == ST_RUN);

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(TX_DEPTH));

`ifdef IO_PORT_CTRL_RX_EN
   assign rx_pop  = io_rd & (sub == 3'd0) & ~rx_empty_in;
   assign rx_byte = rx_empty_in ? 8'h00 : rx_data_in;
`else
   wire unused_rx = &{1'b0, rx_data_in, rx_empty_in};
   assign rx_pop  = 1'b0;
   assign rx_byte = 8'h00;
`endif

   // Pop decision uses the registered count, so a byte pushed into an empty
   // FIFO cannot leave before the following cycle.
   assign pop = rdy_in & ~fifo_empty & ~tx_full_in;

   // Data byte 0x00 at 0x30000 is a no-op; the stop write enqueues 0x00.
   assign push_req  = io_wr & (((sub == 3'd0) & (wdata_in != 8'h00)) | (sub == 3'd4));
   assign push_data = (sub == 3'd4) ? 8'h00 : wdata_in;
   // A full FIFO drops the push even if a pop happens in the same cycle.
   assign push      = push_req & ~fifo_full;

   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      snap_d   = snap_q;
      rdata_d  = rdata_q;
      io_sel_d = io_sel_q;
      ovf_d    = ovf_q;

      if (pop)  head_d = head_q + PW'(1);
      if (push) tail_d = tail_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);

      if (push_req & fifo_full) ovf_d = 1'b1;

      case (state_q)
         ST_RUN:   if (io_wr && sub == 3'd4) state_d = ST_DRAIN;
         ST_DRAIN: if (rdy_in && fifo_empty) state_d = ST_HALTED;
         default:  state_d = ST_HALTED;
      endcase

      if (rdy_in && state_q != ST_HALTED) cnt_d = cnt_q + 32'd1;

      if (rdy_in) io_sel_d = io_hit;

      if (io_rd) begin
         case (sub)
            3'd0:    rdata_d = rx_byte;
            3'd4: begin
               snap_d  = cnt_q;
               rdata_d = cnt_q[7:0];
            end
            3'd5:    rdata_d = snap_q[15:8];
            3'd6:    rdata_d = snap_q[23:16];
            3'd7:    rdata_d = snap_q[31:24];
            default: rdata_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q  <= ST_RUN;
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         cnt_q    <= CNT_INIT;
         snap_q   <= 32'h0;
         rdata_q  <= 8'h00;
         io_sel_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         cnt_q    <= cnt_d;
         snap_q   <= snap_d;
         rdata_q  <= rdata_d;
         io_sel_q <= io_sel_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is not reset; emptiness is tracked solely by the pointers/count.
   always_ff @(posedge clk_in) begin
      if (push) fifo_mem[tail_q] <= push_data;
   end

   assign rdata_out          = rdata_q;
   assign io_sel_out         = io_sel_q;
   assign io_buffer_full_out = (count_q >= CW'(TX_DEPTH - AF_MARGIN));
   // Strobes are gated by rst_in so they vanish the instant reset asserts.
   assign tx_wr_out          = pop & rst_in;
   assign tx_data_out        = tx_wr_out ? fifo_mem[head_q] : 8'h00;
   assign rx_rd_out          = rx_pop & rst_in;
   assign halt_out           = (state_q == ST_HALTED);
   assign ovf_out            = ovf_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Testbench for io_port_ctrl: directed scenarios followed by randomized traffic,
// all checked against a queue-based behavioural model.

module tb_io_port_ctrl;

   localparam int          DEPTH = 8;
   localparam int          AFM   = 2;
   localparam logic [31:0] CINIT = 32'h1234_5678;
`ifdef IO_PORT_CTRL_RX_EN
   localparam bit RX_EN = 1'b1;
`else
   localparam bit RX_EN = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b0;
   logic [31:0] addr_in = 32'h0000_1000;
   logic [7:0]  wdata_in = 8'h00;
   logic        wr_in = 1'b0;
   logic        tx_full_in = 1'b0;
   logic [7:0]  rx_data_in = 8'h00;
   logic        rx_empty_in = 1'b1;
   logic [7:0]  rdata_out, tx_data_out;
   logic        io_sel_out, io_buffer_full_out, tx_wr_out, rx_rd_out, halt_out, ovf_out;

   io_port_ctrl #(.TX_DEPTH(DEPTH), .AF_MARGIN(AFM), .CNT_INIT(CINIT)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .addr_in(addr_in),
      .wdata_in(wdata_in), .wr_in(wr_in), .rdata_out(rdata_out), .io_sel_out(io_sel_out),
      .io_buffer_full_out(io_buffer_full_out), .tx_data_out(tx_data_out), .tx_wr_out(tx_wr_out),
      .tx_full_in(tx_full_in), .rx_data_in(rx_data_in), .rx_empty_in(rx_empty_in),
      .rx_rd_out(rx_rd_out), .halt_out(halt_out), .ovf_out(ovf_out));

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: FIFO as a byte queue, FSM as 0=run 1=drain 2=halted.
   byte unsigned m_q[$];
   int           m_st;
   logic [31:0]  m_cnt, m_snap;
   logic [7:0]   m_rdata;
   logic         m_iosel, m_ovf;

   int          n_strobe;
   logic [7:0]  last_strobe;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_st = 0; m_cnt = CINIT; m_snap = 32'h0;
      m_rdata = 8'h00; m_iosel = 1'b0; m_ovf = 1'b0;
   endtask

   // One clock cycle with the inputs currently driven.
   task automatic cycle();
      bit         io, ewr, erx, push, stopw;
      int         sz;
      logic [2:0] a;
      logic [7:0] pv;
      io = (addr_in[17:16] == 2'b11);
      a  = addr_in[2:0];
      @(negedge clk_in);
      ewr = rdy_in && m_q.size() != 0 && !tx_full_in;
      erx = RX_EN && rdy_in && io && !wr_in && a == 3'd0 && !rx_empty_in;
      chk("tx_wr", 32'(tx_wr_out), 32'(ewr));
      chk("tx_data", 32'(tx_data_out), ewr ? 32'(m_q[0]) : 32'h0);
      chk("rx_rd", 32'(rx_rd_out), 32'(erx));
      chk("afull", 32'(io_buffer_full_out), 32'(m_q.size() >= DEPTH - AFM));
      chk("halt", 32'(halt_out), 32'(m_st == 2));
      chk("ovf", 32'(ovf_out), 32'(m_ovf));
      if (tx_wr_out === 1'b1) begin
         n_strobe++;
         last_strobe = tx_data_out;
      end
      @(posedge clk_in);
      if (rdy_in) begin
         sz = m_q.size();
         push = 0; stopw = 0; pv = 8'h00;
         if (io && !wr_in) begin
            case (a)
               3'd0: m_rdata = (RX_EN && !rx_empty_in) ? rx_data_in : 8'h00;
               3'd4: begin m_snap = m_cnt; m_rdata = m_cnt[7:0]; end
               3'd5: m_rdata = m_snap[15:8];
               3'd6: m_rdata = m_snap[23:16];
               3'd7: m_rdata = m_snap[31:24];
               default: m_rdata = 8'h00;
            endcase
         end
         if (io && wr_in && m_st == 0) begin
            if (a == 3'd0 && wdata_in != 8'h00) begin push = 1; pv = wdata_in; end
            if (a == 3'd4) begin push = 1; stopw = 1; end
         end
         if (sz != 0 && !tx_full_in) void'(m_q.pop_front());
         if (push) begin
            if (sz == DEPTH) m_ovf = 1'b1;
            else m_q.push_back(pv);
         end
         if (m_st != 2) m_cnt = m_cnt + 32'd1;
         if (m_st == 1 && sz == 0) m_st = 2;
         else if (m_st == 0 && stopw) m_st = 1;
         m_iosel = io;
      end
      #1;
      chk("rdata", 32'(rdata_out), 32'(m_rdata));
      chk("io_sel", 32'(io_sel_out), 32'(m_iosel));
      $display("t=%0t addr=%h wr=%0b wd=%h rdy=%0b txf=%0b -> txwr=%0b txd=%h rd=%h q=%0d st=%0d",
               $time, addr_in, wr_in, wdata_in, rdy_in, tx_full_in, tx_wr_out, tx_data_out,
               rdata_out, m_q.size(), m_st);
   endtask

   // Asynchronous reset pulse placed between clock edges; called at posedge+1.
   task automatic do_reset();
      #2 rst_in = 1'b0;
      #1;
      model_reset();
      chk("rst_rdata", 32'(rdata_out), 32'h0);
      chk("rst_io_sel", 32'(io_sel_out), 32'h0);
      chk("rst_afull", 32'(io_buffer_full_out), 32'h0);
      chk("rst_tx_wr", 32'(tx_wr_out), 32'h0);
      chk("rst_tx_data", 32'(tx_data_out), 32'h0);
      chk("rst_rx_rd", 32'(rx_rd_out), 32'h0);
      chk("rst_halt", 32'(halt_out), 32'h0);
      chk("rst_ovf", 32'(ovf_out), 32'h0);
      @(posedge clk_in);
      rdy_in = 1'b0;
      @(negedge clk_in);
      #1 rst_in = 1'b1;
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle();
      addr_in = 32'h0000_1000; wr_in = 1'b0; cycle();
   endtask

   task automatic io_write(input logic [2:0] a, input logic [7:0] d);
      addr_in = 32'h0003_0000 | 32'(a); wr_in = 1'b1; wdata_in = d; cycle();
   endtask

   task automatic io_read(input logic [2:0] a);
      addr_in = 32'h0003_0000 | 32'(a); wr_in = 1'b0; cycle();
   endtask

   initial begin
      logic [31:0] r;
      logic [2:0]  ra;
      model_reset();
      @(posedge clk_in); #1;
      do_reset();

      // Snapshot of the preloaded counter: first active cycle reads 0x30004.
      rdy_in = 1'b1;
      io_read(3'd4); chk("snap_b0", 32'(rdata_out), 32'h78);
      io_read(3'd5); chk("snap_b1", 32'(rdata_out), 32'h56);
      io_read(3'd6); chk("snap_b2", 32'(rdata_out), 32'h34);
      io_read(3'd7); chk("snap_b3", 32'(rdata_out), 32'h12);
      io_read(3'd2);
      idle();

      // 0x41, 0x00, 0x42 -> two strobes.
      n_strobe = 0; tx_full_in = 1'b0;
      io_write(3'd0, 8'h41); io_write(3'd0, 8'h00); io_write(3'd0, 8'h42);
      repeat (4) idle();
      chk("strobes_3w", 32'(n_strobe), 32'd2);
      chk("last_3w", 32'(last_strobe), 32'h42);

      // Almost-full and overflow with the transmitter blocked.
      do_reset(); rdy_in = 1'b1; tx_full_in = 1'b1;
      for (int i = 0; i < 6; i++) io_write(3'd0, 8'(8'h10 + i));
      chk("afull_at6", 32'(io_buffer_full_out), 32'd1);
      for (int i = 0; i < 3; i++) io_write(3'd0, 8'(8'h20 + i));
      chk("ovf_after9", 32'(ovf_out), 32'd1);
      rdy_in = 1'b0; tx_full_in = 1'b0; idle(); idle();
      rdy_in = 1'b1;
      n_strobe = 0;
      repeat (10) idle();
      chk("drain8", 32'(n_strobe), 32'd8);

      // Stop with three bytes queued -> four strobes, last 0x00, then halt.
      do_reset(); rdy_in = 1'b1; tx_full_in = 1'b1;
      io_write(3'd0, 8'hA1); io_write(3'd0, 8'hA2); io_write(3'd0, 8'hA3);
      io_write(3'd4, 8'h99);
      io_write(3'd0, 8'h55);
      n_strobe = 0; tx_full_in = 1'b0;
      repeat (7) idle();
      chk("stop_strobes", 32'(n_strobe), 32'd4);
      chk("stop_last", 32'(last_strobe), 32'h00);
      chk("halted", 32'(halt_out), 32'd1);
      io_read(3'd4); idle(); idle(); io_read(3'd4);

      // Receive path.
      do_reset(); rdy_in = 1'b1;
      rx_empty_in = 1'b0; rx_data_in = 8'h5A;
      io_read(3'd0);
      chk("rx_byte", 32'(rdata_out), RX_EN ? 32'h5A : 32'h00);
      rx_empty_in = 1'b1;
      io_read(3'd0); idle();

      // Reset asserted mid-drain; nothing may be strobed afterwards.
      tx_full_in = 1'b1;
      io_write(3'd0, 8'h61); io_write(3'd0, 8'h62); io_write(3'd0, 8'h63);
      io_write(3'd4, 8'h00);
      tx_full_in = 1'b0; idle();
      do_reset(); rdy_in = 1'b1;
      n_strobe = 0;
      repeat (5) idle();
      chk("no_strobe_after_rst", 32'(n_strobe), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         if (i % 150 == 149) do_reset();
         r = $urandom;
         ra = 3'($urandom_range(0, 7));
         rdy_in      = ($urandom_range(0, 9) != 0);
         tx_full_in  = ($urandom_range(0, 2) == 0);
         rx_empty_in = ($urandom_range(0, 1) == 0);
         rx_data_in  = 8'($urandom);
         wr_in       = ($urandom_range(0, 1) == 0);
         wdata_in    = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
         if (wr_in && ra == 3'd4 && $urandom_range(0, 9) != 0) ra = 3'd0;
         if ($urandom_range(0, 4) == 0)
            addr_in = {r[31:18], 2'($urandom_range(0, 2)), r[15:3], ra};
         else
            addr_in = {r[31:18], 2'b11, r[15:3], ra};
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
